alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter_pkg.sv | 22 ++
 rtl/alu_arbiter_alu.sv | 46 ++++
 rtl/alu_arbiter.sv | 106 ++++++++++
 tb/tb_alu_arbiter.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/alu_arbiter_pkg.sv
// Shared FSM state encoding and ALU op-codes for the two-requester ALU arbiter.
package alu_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [3:0] OP_ADD   = 4'b0000;
  localparam logic [3:0] OP_SUB   = 4'b1000;
  localparam logic [3:0] OP_SLL   = 4'b0001;
  localparam logic [3:0] OP_SLT   = 4'b0010;
  localparam logic [3:0] OP_SLTU  = 4'b1010;
  localparam logic [3:0] OP_SRL   = 4'b0101;
  localparam logic [3:0] OP_SRA   = 4'b1101;
  localparam logic [3:0] OP_XOR   = 4'b0100;
  localparam logic [3:0] OP_OR    = 4'b0110;
  localparam logic [3:0] OP_AND   = 4'b0111;
  localparam logic [3:0] OP_COPYB = 4'b0011;

endpackage

// File: rtl/alu_arbiter_alu.sv
// Combinational ALU: result plus Zero (a==b) and Less flags; unknown op-codes give 0.
module alu_arbiter_alu
  import alu_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [3:0]            ctr,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic [DATA_WIDTH-1:0] out,
  output logic                  zero,
  output logic                  less
);

  localparam int SHW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  logic [SHW-1:0] shamt;
  assign shamt = b[SHW-1:0];

  always_comb begin
    out  = '0;
    less = 1'b0;
    zero = (a == b);
    case (ctr)
      OP_ADD:   out = a + b;
      OP_SUB:   out = a - b;
      OP_SLL:   out = a << shamt;
      OP_SLT: begin
        less = ($signed(a) < $signed(b));
        out  = {{(DATA_WIDTH-1){1'b0}}, less};
      end
      OP_SLTU: begin
        less = (a < b);
        out  = {{(DATA_WIDTH-1){1'b0}}, less};
      end
      OP_SRL:   out = a >> shamt;
      OP_SRA:   out = $signed(a) >>> shamt;
      OP_XOR:   out = a ^ b;
      OP_OR:    out = a | b;
      OP_AND:   out = a & b;
      OP_COPYB: out = b;
      default:  out = '0;
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU between two requesters; one op in flight,
// grant in IDLE, one EXEC cycle, response held in RESP until the consumer takes it.
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req0_valid,
  output logic                  req0_ready,
  input  logic [DATA_WIDTH-1:0] req0_a,
  input  logic [DATA_WIDTH-1:0] req0_b,
  input  logic [3:0]            req0_ctr,
  input  logic                  req1_valid,
  output logic                  req1_ready,
  input  logic [DATA_WIDTH-1:0] req1_a,
  input  logic [DATA_WIDTH-1:0] req1_b,
  input  logic [3:0]            req1_ctr,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic                  resp_id,
  output logic [DATA_WIDTH-1:0] resp_out,
  output logic                  resp_zero,
  output logic                  resp_less,
  output logic                  busy
);

  state_t                state;
  logic                  last_grant;
  logic [DATA_WIDTH-1:0] op_a;
  logic [DATA_WIDTH-1:0] op_b;
  logic [3:0]            op_ctr;
  logic [DATA_WIDTH-1:0] alu_out;
  logic                  alu_zero;
  logic                  alu_less;
  logic                  grant;
  logic                  grant_id;

  // With both valid, serve the one opposite the last grant; otherwise whoever is valid.
  assign grant      = (state == IDLE) && (req0_valid || req1_valid);
  assign grant_id   = (req0_valid && req1_valid) ? ~last_grant : req1_valid;
  assign req0_ready = rst_n && grant && !grant_id;
  assign req1_ready = rst_n && grant && grant_id;

  alu_arbiter_alu #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_alu (
    .ctr  (op_ctr),
    .a    (op_a),
    .b    (op_b),
    .out  (alu_out),
    .zero (alu_zero),
    .less (alu_less)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      op_a       <= '0;
      op_b       <= '0;
      op_ctr     <= '0;
      resp_valid <= 1'b0;
      resp_id    <= 1'b0;
      resp_out   <= '0;
      resp_zero  <= 1'b0;
      resp_less  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant) begin
            op_a       <= grant_id ? req1_a   : req0_a;
            op_b       <= grant_id ? req1_b   : req0_b;
            op_ctr     <= grant_id ? req1_ctr : req0_ctr;
            resp_id    <= grant_id;
            last_grant <= grant_id;
            busy       <= 1'b1;
            state      <= EXEC;
          end
        end
        EXEC: begin
          resp_out   <= alu_out;
          resp_zero  <= alu_zero;
          resp_less  <= alu_less;
          resp_valid <= 1'b1;
          state      <= RESP;
        end
        RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            busy       <= 1'b0;
            state      <= IDLE;
          end
        end
        default: begin
          resp_valid <= 1'b0;
          busy       <= 1'b0;
          state      <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: vector table of ALU ops plus arbitration, backpressure and reset sequences.
module tb_alu_arbiter;
  import alu_arbiter_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0_valid, req1_valid;
  logic        req0_ready, req1_ready;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic [3:0]  req0_ctr, req1_ctr;
  logic        resp_valid, resp_ready, resp_id, resp_zero, resp_less, busy;
  logic [31:0] resp_out;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  alu_arbiter #(.DATA_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_ctr(req0_ctr),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_ctr(req1_ctr),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id), .resp_out(resp_out),
    .resp_zero(resp_zero), .resp_less(resp_less), .busy(busy)
  );

  typedef struct {
    logic        id;
    logic [3:0]  ctr;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] out;
    logic        zero;
    logic        less;
  } vec_t;

  vec_t vecs[14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic run_vec(input vec_t v);
    next_cycle();
    if (v.id) begin
      req1_valid = 1'b1; req1_a = v.a; req1_b = v.b; req1_ctr = v.ctr;
    end else begin
      req0_valid = 1'b1; req0_a = v.a; req0_b = v.b; req0_ctr = v.ctr;
    end
    @(negedge clk);
    chk("vec_grant", {30'd0, req1_ready, req0_ready}, v.id ? 32'd2 : 32'd1);
    next_cycle();
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(negedge clk);
    chk("vec_exec", {30'd0, busy, resp_valid}, 32'd2);
    next_cycle();
    @(negedge clk);
    chk("vec_resp_valid", {31'd0, resp_valid}, 32'd1);
    chk("vec_resp_id", {31'd0, resp_id}, {31'd0, v.id});
    chk("vec_resp_out", resp_out, v.out);
    chk("vec_resp_flags", {30'd0, resp_zero, resp_less}, {30'd0, v.zero, v.less});
    next_cycle();
    @(negedge clk);
    chk("vec_idle", {30'd0, busy, resp_valid}, 32'd0);
  endtask

  initial begin
    vecs[0]  = '{1'b0, OP_ADD,   32'd5,        32'd7,        32'd12,       1'b0, 1'b0};
    vecs[1]  = '{1'b1, OP_SUB,   32'd3,        32'd5,        32'hFFFFFFFE, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, OP_SUB,   32'd9,        32'd9,        32'd0,        1'b1, 1'b0};
    vecs[3]  = '{1'b1, OP_SLL,   32'd1,        32'd31,       32'h80000000, 1'b0, 1'b0};
    vecs[4]  = '{1'b0, OP_SLTU,  32'd1,        32'hFFFFFFFF, 32'd1,        1'b0, 1'b1};
    vecs[5]  = '{1'b1, OP_SLT,   32'd1,        32'hFFFFFFFF, 32'd0,        1'b0, 1'b0};
    vecs[6]  = '{1'b0, OP_SLT,   32'hFFFFFFFF, 32'd1,        32'd1,        1'b0, 1'b1};
    vecs[7]  = '{1'b1, OP_SRL,   32'h80000000, 32'd4,        32'h08000000, 1'b0, 1'b0};
    vecs[8]  = '{1'b0, OP_XOR,   32'h0000F0F0, 32'h0000FF00, 32'h00000FF0, 1'b0, 1'b0};
    vecs[9]  = '{1'b1, OP_OR,    32'h000000F0, 32'h0000000F, 32'h000000FF, 1'b0, 1'b0};
    vecs[10] = '{1'b0, OP_AND,   32'h000000F0, 32'h0000003C, 32'h00000030, 1'b0, 1'b0};
    vecs[11] = '{1'b1, OP_COPYB, 32'd1,        32'h0000ABCD, 32'h0000ABCD, 1'b0, 1'b0};
    vecs[12] = '{1'b0, 4'b1111,  32'd3,        32'd3,        32'd0,        1'b1, 1'b0};
    vecs[13] = '{1'b1, OP_ADD,   32'hFFFFFFFF, 32'd2,        32'd1,        1'b0, 1'b0};

    rst_n = 1'b0; resp_ready = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_a = 32'd0; req0_b = 32'd0; req0_ctr = OP_ADD;
    req1_a = 32'd0; req1_b = 32'd0; req1_ctr = OP_ADD;
    repeat (3) @(posedge clk);
    #1;

    // Reset state, with both requesters already valid.
    req0_valid = 1'b1; req0_a = 32'd1; req0_b = 32'd2;
    req1_valid = 1'b1; req1_a = 32'd3; req1_b = 32'd4;
    @(negedge clk);
    chk("rst_ready", {30'd0, req1_ready, req0_ready}, 32'd0);
    chk("rst_busy_valid", {30'd0, busy, resp_valid}, 32'd0);
    chk("rst_resp", {29'd0, resp_id, resp_zero, resp_less}, 32'd0);
    chk("rst_out", resp_out, 32'd0);

    // Both valid continuously: grants 0,1,0,1 every third cycle.
    next_cycle();
    rst_n = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      chk("rr_grant", {30'd0, req1_ready, req0_ready},
          (c % 3 != 0) ? 32'd0 : (((c / 3) % 2 == 0) ? 32'd1 : 32'd2));
      next_cycle();
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(negedge clk);
    chk("rr_drained", {31'd0, busy}, 32'd0);

    for (int i = 0; i < 14; i++) run_vec(vecs[i]);

    // Backpressure: SRA response held while resp_ready is low.
    next_cycle();
    resp_ready = 1'b0;
    req1_valid = 1'b1; req1_a = 32'h80000000; req1_b = 32'd4; req1_ctr = OP_SRA;
    @(negedge clk);
    chk("bp_grant", {30'd0, req1_ready, req0_ready}, 32'd2);
    next_cycle();
    req1_valid = 1'b0;
    next_cycle();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("bp_hold_valid", {30'd0, busy, resp_valid}, 32'd3);
      chk("bp_hold_out", resp_out, 32'hF8000000);
      chk("bp_hold_id", {31'd0, resp_id}, 32'd1);
      next_cycle();
    end
    resp_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_out", {31'd0, resp_valid}, 32'd1);
    next_cycle();
    @(negedge clk);
    chk("bp_idle", {30'd0, busy, resp_valid}, 32'd0);

    // Reset during EXEC aborts; pointer returns to favouring requester 0.
    next_cycle();
    req0_valid = 1'b1; req0_a = 32'd5; req0_b = 32'd7; req0_ctr = OP_ADD;
    @(negedge clk);
    chk("abort_grant", {30'd0, req1_ready, req0_ready}, 32'd1);
    next_cycle();
    rst_n = 1'b0; req1_valid = 1'b1;
    @(negedge clk);
    chk("abort_exec_no_resp", {31'd0, resp_valid}, 32'd0);
    next_cycle();
    @(negedge clk);
    chk("abort_idle", {30'd0, busy, resp_valid}, 32'd0);
    chk("abort_ready_in_rst", {30'd0, req1_ready, req0_ready}, 32'd0);
    next_cycle();
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_grant", {30'd0, req1_ready, req0_ready}, 32'd1);
    next_cycle();
    req0_valid = 1'b0; req1_valid = 1'b0;
    next_cycle();
    @(negedge clk);
    chk("post_rst_resp_id", {31'd0, resp_id}, 32'd0);
    chk("post_rst_resp_out", resp_out, 32'd12);
    next_cycle();
    @(negedge clk);
    chk("post_rst_idle", {31'd0, busy}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
